// File: rtl/md_iter_if.sv
// md_iter_if: request/response bundle between the execute stage and the iterative mul/div unit
interface md_iter_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            wb_en;

    modport master (
        output start, funct3, op_a, op_b, rd_in,
        input  busy, done, result, rd_out, wb_en
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in,
        output busy, done, result, rd_out, wb_en
    );
endinterface

// File: rtl/md_iter_unit.sv
// md_iter_unit: radix-2 iterative RV32M multiply/divide unit driving the register-file write port
module md_iter_unit #(
    parameter int XLEN = 32
) (
    input logic      clk,
    input logic      rst_n,
    md_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t            state, nxt;
    logic [2:0]        f3;
    logic [4:0]        rd;
    logic [XLEN-1:0]   am, bm, res, q, r, fin, spc_res;
    logic [2*XLEN-1:0] acc, acc_n, prod;
    logic [XLEN:0]     sum, rsh, diff;
    logic [5:0]        cnt;
    logic              sa, neg, ovf, sgn_a, sgn_b, a_neg, b_neg, spc, last;

    always_comb begin
        sgn_a   = bus.funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
        sgn_b   = bus.funct3 inside {3'd0, 3'd1, 3'd4, 3'd6};
        a_neg   = sgn_a & bus.op_a[XLEN-1];
        b_neg   = sgn_b & bus.op_b[XLEN-1];
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (bm[cnt[4:0]] ? {1'b0, am} : '0);
        rsh     = {acc[2*XLEN-1:XLEN], am[~cnt[4:0]]};
        diff    = rsh - {1'b0, bm};
        // MUL shifts the product right past the multiplier; DIV shifts quotient bits in from the right
        acc_n   = (state == MUL) ? {sum, acc[XLEN-1:1]}
                                 : {diff[XLEN] ? rsh[XLEN-1:0] : diff[XLEN-1:0], acc[XLEN-2:0], ~diff[XLEN]};
        prod    = neg ? -acc_n : acc_n;
        q       = neg ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
        r       = sa ? -acc_n[2*XLEN-1:XLEN] : acc_n[2*XLEN-1:XLEN];
        fin     = (state == MUL) ? ((f3[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                                 : (f3[1] ? r : q);
        spc     = (state == DIV) & (~|bm | ovf);
        spc_res = ~|bm ? (f3[1] ? (sa ? -am : am) : '1)
                       : (f3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
        last    = cnt == 6'(XLEN-1);
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = bus.start ? (bus.funct3[2] ? DIV : MUL) : IDLE;
            MUL, DIV: nxt = (last | spc) ? DONE : state;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3  <= '0;
            rd  <= '0;
            am  <= '0;
            bm  <= '0;
            sa  <= 1'b0;
            neg <= 1'b0;
            ovf <= 1'b0;
            acc <= '0;
            cnt <= '0;
            res <= '0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                f3  <= bus.funct3;
                rd  <= bus.rd_in;
                am  <= a_neg ? -bus.op_a : bus.op_a;
                bm  <= b_neg ? -bus.op_b : bus.op_b;
                sa  <= a_neg;
                neg <= a_neg ^ b_neg;
                ovf <= bus.funct3[2] & ~bus.funct3[0] & (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.op_b);
                acc <= '0;
                cnt <= '0;
            end
        end else if (spc) begin
            res <= spc_res;
        end else if (state != DONE) begin
            acc <= acc_n;
            cnt <= cnt + 6'd1;
            if (last) res <= fin;
        end
    end

    assign bus.busy   = state != IDLE;
    assign bus.done   = state == DONE;
    assign bus.result = res;
    assign bus.rd_out = rd;
    assign bus.wb_en  = (state == DONE) & |rd;
endmodule

// File: tb/tb_md_iter_unit.sv
// tb_md_iter_unit: table-driven and random scoreboard bench for md_iter_unit
module tb_md_iter_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    md_iter_if bus();
    md_iter_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int nchk = 0;
    int npass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        int          lat;
    } vec_t;
    vec_t tv[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        logic signed [31:0] sq, sr;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (f3 == 3'd0) begin p = ua * ub; return p[31:0]; end
        if (f3 == 3'd1) begin p = sa * sb; return p[63:32]; end
        if (f3 == 3'd2) begin p = sa * ub; return p[63:32]; end
        if (f3 == 3'd3) begin p = ua * ub; return p[63:32]; end
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (f3 == 3'd5) return a / b;
        if (f3 == 3'd7) return a % b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        return f3[1] ? sr : sq;
    endfunction

    function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return (f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 2 : 33;
    endfunction

    function automatic logic [31:0] pick();
        int k;
        k = $urandom_range(0, 7);
        return k == 0 ? 32'd0 : k == 1 ? 32'h8000_0000 : k == 2 ? 32'hFFFF_FFFF :
               k == 3 ? 32'($urandom_range(0, 20)) : $urandom;
    endfunction

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] er, input int el,
                         input bit pk, output int dcyc);
        exp_t e, g;
        int t0;
        bit seen, bok;
        seen = 0;
        bok = 1;
        dcyc = 0;
        e.res = er;
        e.rd = rd;
        e.lat = el;
        @(negedge clk);
        if (bus.busy !== 1'b0) bok = 0;
        bus.start = 1'b1;
        bus.funct3 = f3;
        bus.op_a = a;
        bus.op_b = b;
        bus.rd_in = rd;
        t0 = cyc;
        sbq.push_back(e);
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(negedge clk);
            bus.start = pk && i == 5;
            if (i == 1) begin
                bus.funct3 = 3'($urandom);
                bus.op_a = $urandom;
                bus.op_b = $urandom;
                bus.rd_in = 5'($urandom);
            end
            if (bus.busy !== 1'b1) bok = 0;
            if (bus.done === 1'b1) begin
                seen = 1;
                g = sbq.pop_front();
                chk($sformatf("result f3=%0d a=%h b=%h", f3, a, b), bus.result, g.res);
                chk("rd_out", bus.rd_out, g.rd);
                chk("wb_en", bus.wb_en, g.rd != 5'd0);
                chk($sformatf("latency f3=%0d", f3), cyc - t0, g.lat);
                dcyc = cyc;
                if (pk) bus.start = 1'b1;
            end
        end
        if (!seen) begin
            nchk++;
            void'(sbq.pop_front());
            $display("FAIL timeout: no done within 60 cycles for f3=%0d, required done", f3);
        end
        chk("busy_during_op", bok, 1'b1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, d2, nd;
        logic [2:0] f;
        logic [31:0] a, b;
        bus.start = 1'b0;
        bus.funct3 = 3'd0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.rd_in = '0;
        tv[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33};
        tv[1]  = '{3'd1, 32'd7,         32'hFFFF_FFFD, 5'd6,  32'hFFFF_FFFF, 33};
        tv[2]  = '{3'd3, 32'd7,         32'hFFFF_FFFD, 5'd7,  32'h0000_0006, 33};
        tv[3]  = '{3'd2, 32'd7,         32'hFFFF_FFFD, 5'd8,  32'h0000_0006, 33};
        tv[4]  = '{3'd4, 32'hFFFF_FFEC, 32'd3,         5'd9,  32'hFFFF_FFFA, 33};
        tv[5]  = '{3'd6, 32'hFFFF_FFEC, 32'd3,         5'd10, 32'hFFFF_FFFE, 33};
        tv[6]  = '{3'd5, 32'd100,       32'd7,         5'd11, 32'd14,        33};
        tv[7]  = '{3'd7, 32'd100,       32'd7,         5'd12, 32'd2,         33};
        tv[8]  = '{3'd5, 32'h1234,      32'd0,         5'd13, 32'hFFFF_FFFF, 2};
        tv[9]  = '{3'd6, 32'h1234,      32'd0,         5'd14, 32'h1234,      2};
        tv[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 2};
        tv[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         2};
        tv[12] = '{3'd0, 32'd3,         32'd4,         5'd0,  32'd12,        33};
        tv[13] = '{3'd4, 32'h8000_0000, 32'd1,         5'd17, 32'h8000_0000, 33};
        tv[14] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0,         33};
        tv[15] = '{3'd6, 32'hFFFF_FFFB, 32'd0,         5'd19, 32'hFFFF_FFFB, 2};

        repeat (3) @(negedge clk);
        chk("reset busy", bus.busy, 1'b0);
        chk("reset done", bus.done, 1'b0);
        chk("reset wb_en", bus.wb_en, 1'b0);
        chk("reset result", bus.result, 32'd0);
        chk("reset rd_out", bus.rd_out, 5'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            do_op(tv[i].f3, tv[i].a, tv[i].b, tv[i].rd, tv[i].res, tv[i].lat, 1'b0, d1);

        do_op(3'd0, 32'd3, 32'd5, 5'd1, 32'd15, 33, 1'b1, d1);
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_in_done_ignored busy", bus.busy, 1'b0);
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) nd++;
        end
        chk("ignored_starts stay idle", nd, 0);
        chk("ignored_starts result kept", bus.result, 32'd15);

        do_op(3'd0, 32'd2, 32'd3, 5'd2, 32'd6, 33, 1'b0, d1);
        do_op(3'd5, 32'd100, 32'd7, 5'd3, 32'd14, 33, 1'b0, d2);
        chk("back_to_back spacing", d2 - d1, 34);

        @(negedge clk);
        bus.start = 1'b1;
        bus.funct3 = 3'd3;
        bus.op_a = 32'hFFFF_FFFF;
        bus.op_b = 32'hFFFF_FFFF;
        bus.rd_in = 5'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset busy", bus.busy, 1'b0);
        chk("async_reset done", bus.done, 1'b0);
        chk("async_reset wb_en", bus.wb_en, 1'b0);
        chk("async_reset result", bus.result, 32'd0);
        chk("async_reset rd_out", bus.rd_out, 5'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) nd++;
        end
        chk("no_done_after_reset", nd, 0);
        do_op(3'd0, 32'd6, 32'd7, 5'd3, 32'd42, 33, 1'b0, d1);

        for (int n = 0; n < 200; n++)
            for (int k = 0; k < 8; k++) begin
                f = 3'(k);
                a = pick();
                b = pick();
                do_op(f, a, b, 5'($urandom), model(f, a, b), lat_of(f, a, b), 1'b0, d1);
            end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
